tdm_mux4_1: RTL and testbench

TDM_MUX4_1 -- requirements
Module: tdm_mux4_1

---
 rtl/tdm_mux4_1.sv | 103 ++++++++++
 tb/tb_tdm_mux4_1.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux4_1.sv
// Four-lane valid/ready merge onto one registered output stream, round-robin arbitrated.
// Define TDM_MUX_CNT_EN to add the 16-bit xfer_cnt output-transfer counter.
module tdm_mux4_1 #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
`ifdef TDM_MUX_CNT_EN
  output logic [15:0]    xfer_cnt,
`endif
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  input  logic           out_ready
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   sel_q, sel_d;

  logic         slot_free;
  logic         grant;
  logic         grant_any;
  logic [1:0]   grant_idx;
  logic [1:0]   lane;

  // Walk offsets from farthest to nearest so the lane closest to ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    lane      = '0;
    for (int k = 3; k >= 0; k--) begin
      lane = ptr_q + 2'(k);
      if (in_valid[lane]) begin
        grant_any = 1'b1;
        grant_idx = lane;
      end
    end
  end

  assign slot_free = (state_q == StEmpty) || out_ready;
  // Gating with rst keeps in_ready low while the registers are held in reset.
  assign grant     = grant_any && slot_free && !rst;
  assign in_ready  = grant ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (grant) begin
      state_d = StFull;
      data_d  = in_data[grant_idx*W +: W];
      sel_d   = grant_idx;
      ptr_d   = grant_idx + 2'd1;
    end else begin
      unique case (state_q)
        StEmpty: state_d = StEmpty;
        StFull:  if (out_ready) state_d = StEmpty;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef TDM_MUX_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tdm_mux4_1.sv
// Self-checking bench for tdm_mux4_1: fixed vectors, corner sequences, random vs reference model.
module tb_tdm_mux4_1;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;
`ifdef TDM_MUX_CNT_EN
  logic [15:0]    xfer_cnt;
`endif

  tdm_mux4_1 #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
`ifdef TDM_MUX_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: holding slot, round-robin pointer, transfer count.
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  int         m_ptr;
  logic [15:0] m_cnt;
  logic [3:0] m_rdy;
  logic [3:0] s_rdy;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 2'd0;
    m_ptr   = 0;
    m_cnt   = 16'd0;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [3:0] iv, input logic [31:0] d, input logic ordy);
    int g;
    bit free;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    free = !m_valid || ordy;
    g = -1;
    if (free) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    m_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
    #1 s_rdy = in_ready;
    @(posedge clk);
    if (m_valid && ordy) m_cnt = m_cnt + 16'd1;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = d[g*8 +: 8];
      m_sel   = 2'(g);
      m_ptr   = (g + 1) % 4;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    in_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] rr;
    rr = {8'h13, 8'h12, 8'h11, 8'h10};
    tbl[0] = '{4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1] = '{4'b0000, rr, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    tbl[2] = '{4'b1000, rr, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[3] = '{4'b1111, rr, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[4] = '{4'b1111, rr, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[5] = '{4'b1111, rr, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[6] = '{4'b1111, rr, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[7] = '{4'b1111, rr, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[8] = '{4'b0000, rr, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};

    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    rst      = 1'b0;
    in_valid = 4'b0000;

    // Single lane, then round-robin with no bubbles, then drain.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d in_ready", i), 32'(s_rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].exp_d));
      chk($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(tbl[i].exp_s));
    end

    // Backpressure: lane1 word held for 5 cycles, then released with a same-edge reload.
    reset_dut();
    cycle(4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00}, 1'b0);
    chk("bp load in_ready", 32'(s_rdy), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, 1'b0);
      chk($sformatf("bp%0d in_ready", i), 32'(s_rdy), 32'd0);
      chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d out_data", i), 32'(out_data), 32'h3C);
      chk($sformatf("bp%0d out_sel", i), 32'(out_sel), 32'd1);
    end
    cycle(4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, 1'b1);
    chk("bp release in_ready", 32'(s_rdy), 32'b0100);
    chk("bp release out_valid", 32'(out_valid), 32'd1);
    chk("bp release out_data", 32'(out_data), 32'hC2);
    chk("bp release out_sel", 32'(out_sel), 32'd2);

    // Drain: slot empties, pointer stays at lane3.
    cycle(4'b0000, 32'h0, 1'b1);
    chk("drain out_valid", 32'(out_valid), 32'd0);
    chk("drain in_ready", 32'(s_rdy), 32'd0);
    cycle(4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, 1'b1);
    chk("drain ptr in_ready", 32'(s_rdy), 32'b1000);
    chk("drain ptr out_sel", 32'(out_sel), 32'd3);

    // Asynchronous reset while FULL, away from any clock edge.
    in_valid  = 4'b1010;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_sel", 32'(out_sel), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(4'b1010, {8'h77, 8'h66, 8'h55, 8'h44}, 1'b1);
    chk("post rst in_ready", 32'(s_rdy), 32'b0010);
    chk("post rst out_sel", 32'(out_sel), 32'd1);
    chk("post rst out_data", 32'(out_data), 32'h55);

    // Random traffic against the reference model.
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
      chk($sformatf("rnd%0d in_ready", i), 32'(s_rdy), 32'(m_rdy));
      chk($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(m_valid));
      chk($sformatf("rnd%0d out_data", i), 32'(out_data), 32'(m_data));
      chk($sformatf("rnd%0d out_sel", i), 32'(out_sel), 32'(m_sel));
`ifdef TDM_MUX_CNT_EN
      chk($sformatf("rnd%0d xfer_cnt", i), 32'(xfer_cnt), 32'(m_cnt));
`endif
    end

`ifdef TDM_MUX_CNT_EN
    begin
      int n;
      logic [15:0] exp_tail[3];
      exp_tail[0] = 16'hFFFF;
      exp_tail[1] = 16'h0000;
      exp_tail[2] = 16'h0001;
      reset_dut();
      n = 0;
      while (m_cnt != 16'hFFFE && n < 70000) begin
        cycle(4'b0001, 32'h5A, 1'b1);
        n++;
      end
      chk("cnt preload", 32'(xfer_cnt), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
        cycle(4'b0001, 32'h5A, 1'b1);
        chk($sformatf("cnt wrap%0d", i), 32'(xfer_cnt), 32'(exp_tail[i]));
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
